ring_count_monitor: RTL

Passive observer/checker for the rotating ring counter that our stimulus modules drive. The stimulus writes load, data and mod into the counter; this block reads the same stream plus the counter's count output, keeps its own reference model, and reports mismatches, lock state and ring position. It sits beside the counter in bench and self-test builds. It never drives the counter.

---
 rtl/ring_count_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ring_count_monitor.sv
// Passive reference-model checker for a rotating ring counter: tracks load/reset/rotate beats and flags mismatches.
// Latency 1 cycle (beat N visible in cycle N+1); observer only, no backpressure.
module ring_count_monitor #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int FAULT_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     load,
  input  logic                     dut_rst,
  input  logic                     mod,
  input  logic [WIDTH-1:0]         data,
  input  logic [WIDTH-1:0]         count,
  output logic [WIDTH-1:0]         expected,
  output logic                     mismatch,
  output logic [ERR_W-1:0]         err_count,
  output logic                     sticky_err,
  output logic                     locked,
  output logic                     fault,
  output logic                     onehot_ok,
  output logic [$clog2(WIDTH)-1:0] position
);

  localparam int POS_W  = $clog2(WIDTH);
  localparam int MISS_W = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic              mismatch_q, mismatch_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              onehot_q, onehot_d;
  logic [POS_W-1:0]  pos_q, pos_d;

  logic [WIDTH-1:0]  next_val;
  logic              hit;
  logic              is_onehot;
  logic [POS_W-1:0]  pos_idx;
  logic              resync;

  // Model's next value: load beats the counter's own reset, which beats rotation.
  always_comb begin
    next_val = expected_q;
    if (load) begin
      next_val = data;
    end else if (dut_rst) begin
      next_val = WIDTH'(1);
    end else if (mod) begin
      next_val = {expected_q[WIDTH-2:0], expected_q[WIDTH-1]};
    end else begin
      next_val = {expected_q[0], expected_q[WIDTH-1:1]};
    end
  end

  assign hit       = (count == expected_q);
  assign is_onehot = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
  assign resync    = load | dut_rst;

  always_comb begin
    pos_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i]) begin
        pos_idx = POS_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    sticky_d   = sticky_q;
    miss_d     = miss_q;
    onehot_d   = onehot_q;
    pos_d      = pos_q;

    if (valid) begin
      onehot_d = is_onehot;
      if (is_onehot) begin
        pos_d = pos_idx;
      end

      unique case (state_q)
        ST_UNLOCKED: begin
          if (resync) begin
            expected_d = next_val;
            state_d    = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // The compare always uses the pre-update expected, even on a load beat.
          expected_d = next_val;
          if (!hit) begin
            mismatch_d = 1'b1;
            sticky_d   = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            if (miss_q == MISS_W'(FAULT_LIMIT - 1)) begin
              miss_d  = MISS_W'(FAULT_LIMIT);
              state_d = ST_FAULT;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        ST_FAULT: begin
          if (resync) begin
            expected_d = next_val;
            miss_d     = '0;
            state_d    = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_UNLOCKED;
      expected_q <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      sticky_q   <= 1'b0;
      miss_q     <= '0;
      onehot_q   <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      miss_q     <= miss_d;
      onehot_q   <= onehot_d;
      pos_q      <= pos_d;
    end
  end

  assign expected   = expected_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign sticky_err = sticky_q;
  assign locked     = (state_q == ST_LOCKED);
  assign fault      = (state_q == ST_FAULT);
  assign onehot_ok  = onehot_q;
  assign position   = pos_q;

endmodule
